// File: rtl/mc_mem_bridge.sv
// Core-to-system-memory bridge: queues 8/16/32-bit core requests and reissues them as lane-steered 64-bit accesses.
// Optional alignment checking is enabled with the MC_MEM_BRIDGE_ALIGN_CHK_EN macro.
module mc_mem_bridge #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned RDEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ACT,
    input  logic        CMD,
    input  logic [1:0]  SIZE,
    input  logic [44:0] ADDRESS,
    input  logic [31:0] DTo,
    output logic        NEXT,
    output logic        DRDY,
    output logic [31:0] DTi,
    output logic        MEM_ACT,
    output logic        MEM_CMD,
    output logic [41:0] MEM_ADDR,
    output logic [7:0]  MEM_BE,
    output logic [63:0] MEM_DTO,
    input  logic        MEM_NEXT,
    input  logic        MEM_DRDY,
    input  logic [63:0] MEM_DTI,
    output logic        ERR
);

    localparam int unsigned QAW = $clog2(QDEPTH);
    localparam int unsigned QCW = QAW + 1;
    localparam int unsigned RAW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int unsigned RCW = $clog2(RDEPTH + 1);

    typedef struct packed {
        logic        cmd;
        logic [1:0]  size;
        logic [44:0] addr;
        logic [31:0] dto;
    } req_t;

    typedef struct packed {
        logic [2:0] off;
        logic [1:0] size;
    } tag_t;

    req_t           queue_q [QDEPTH];
    tag_t           tags_q  [RDEPTH];

    logic [QCW-1:0] cnt_q, cnt_d;
    logic [QAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RCW-1:0] rsv_q, rsv_d;
    logic [RCW-1:0] tag_cnt_q, tag_cnt_d;
    logic [RAW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic           mem_act_q, mem_act_d;
    logic           mem_cmd_q, mem_cmd_d;
    logic [41:0]    mem_addr_q, mem_addr_d;
    logic [7:0]     mem_be_q, mem_be_d;
    logic [63:0]    mem_dto_q, mem_dto_d;
    tag_t           mem_tag_q, mem_tag_d;
    logic           drdy_q, drdy_d;
    logic [31:0]    dti_q, dti_d;
    logic           err_q, err_d;

    logic           push, fire, slot_free, cand_vld, cand_mis, push_mis;
    logic           load, drop, tag_push, ret;
    logic [QAW-1:0] cand_idx;
    req_t           req_in, cand;
    logic [2:0]     om;
    logic [7:0]     st_be;
    logic [63:0]    st_dto;
    tag_t           ret_tag;
    logic [31:0]    ret_shift, ret_data;

    function automatic logic [RAW-1:0] rinc(input logic [RAW-1:0] p);
        return (p == RAW'(RDEPTH - 1)) ? '0 : p + RAW'(1);
    endfunction

    assign NEXT     = (cnt_q < QCW'(QDEPTH));
    assign DRDY     = drdy_q;
    assign DTi      = dti_q;
    assign MEM_ACT  = mem_act_q;
    assign MEM_CMD  = mem_cmd_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_BE   = mem_be_q;
    assign MEM_DTO  = mem_dto_q;
    assign ERR      = err_q;

    assign req_in    = '{cmd: CMD, size: SIZE, addr: ADDRESS, dto: DTo};
    assign push      = ACT && NEXT;
    assign fire      = mem_act_q && MEM_NEXT;
    assign slot_free = !mem_act_q || fire;
    // The entry behind the presented one becomes the load candidate on a transfer.
    assign cand_idx  = rd_ptr_q + QAW'(fire);
    assign cand_vld  = (cnt_q > QCW'(fire));
    assign cand      = queue_q[cand_idx];

`ifdef MC_MEM_BRIDGE_ALIGN_CHK_EN
    assign cand_mis = ((cand.size == 2'b01) && cand.addr[0]) ||
                      (cand.size[1] && (cand.addr[1:0] != 2'b00));
    assign push_mis = ((SIZE == 2'b01) && ADDRESS[0]) ||
                      (SIZE[1] && (ADDRESS[1:0] != 2'b00));
`else
    assign cand_mis = 1'b0;
    assign push_mis = 1'b0;
`endif

    // Reads reserve a return slot when loaded, so the tag FIFO can never overflow.
    assign load     = slot_free && cand_vld && !cand_mis &&
                      (!cand.cmd || (rsv_q < RCW'(RDEPTH)));
    assign drop     = slot_free && cand_vld && cand_mis &&
                      (!cand.cmd || (rsv_q == '0));
    assign tag_push = fire && mem_cmd_q;
    assign ret      = MEM_DRDY && (tag_cnt_q != '0);

    // Lane steering of the load candidate.
    always_comb begin
        om     = cand.addr[2:0];
        st_be  = 8'h01 << om;
        st_dto = {8{cand.dto[7:0]}};
        case (cand.size)
            2'b00: begin
                om     = cand.addr[2:0];
                st_be  = 8'h01 << om;
                st_dto = {8{cand.dto[7:0]}};
            end
            2'b01: begin
                om     = {cand.addr[2:1], 1'b0};
                st_be  = 8'h03 << om;
                st_dto = {4{cand.dto[15:0]}};
            end
            default: begin
                om     = {cand.addr[2], 2'b00};
                st_be  = 8'h0F << om;
                st_dto = {2{cand.dto}};
            end
        endcase
    end

    // Read-return lane extraction.
    always_comb begin
        ret_tag   = tags_q[tag_rd_q];
        ret_shift = 32'(MEM_DTI >> {ret_tag.off, 3'b000});
        case (ret_tag.size)
            2'b00:   ret_data = {24'h0, ret_shift[7:0]};
            2'b01:   ret_data = {16'h0, ret_shift[15:0]};
            default: ret_data = ret_shift;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q + QCW'(push) - QCW'(fire) - QCW'(drop);
        wr_ptr_d   = wr_ptr_q + QAW'(push);
        rd_ptr_d   = rd_ptr_q + QAW'(fire) + QAW'(drop);
        rsv_d      = rsv_q + RCW'(load && cand.cmd) - RCW'(ret);
        tag_cnt_d  = tag_cnt_q + RCW'(tag_push) - RCW'(ret);
        tag_wr_d   = tag_push ? rinc(tag_wr_q) : tag_wr_q;
        tag_rd_d   = ret ? rinc(tag_rd_q) : tag_rd_q;
        mem_act_d  = mem_act_q && !fire;
        mem_cmd_d  = mem_cmd_q;
        mem_addr_d = mem_addr_q;
        mem_be_d   = mem_be_q;
        mem_dto_d  = mem_dto_q;
        mem_tag_d  = mem_tag_q;
        drdy_d     = 1'b0;
        dti_d      = dti_q;
        err_d      = err_q || (push && push_mis);

        if (load) begin
            mem_act_d      = 1'b1;
            mem_cmd_d      = cand.cmd;
            mem_addr_d     = cand.addr[44:3];
            mem_be_d       = st_be;
            mem_dto_d      = st_dto;
            mem_tag_d.off  = om;
            mem_tag_d.size = cand.size;
        end

        if (ret) begin
            drdy_d = 1'b1;
            dti_d  = ret_data;
        end else if (drop && cand.cmd) begin
            drdy_d = 1'b1;
            dti_d  = 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) queue_q[wr_ptr_q] <= req_in;
    end

    always_ff @(posedge CLK) begin
        if (tag_push) tags_q[tag_wr_q] <= mem_tag_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rsv_q      <= '0;
            tag_cnt_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            mem_act_q  <= 1'b0;
            mem_cmd_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_be_q   <= '0;
            mem_dto_q  <= '0;
            mem_tag_q  <= '0;
            drdy_q     <= 1'b0;
            dti_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rsv_q      <= rsv_d;
            tag_cnt_q  <= tag_cnt_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            mem_act_q  <= mem_act_d;
            mem_cmd_q  <= mem_cmd_d;
            mem_addr_q <= mem_addr_d;
            mem_be_q   <= mem_be_d;
            mem_dto_q  <= mem_dto_d;
            mem_tag_q  <= mem_tag_d;
            drdy_q     <= drdy_d;
            dti_q      <= dti_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mc_mem_bridge.sv
// Directed bench for mc_mem_bridge: byte write, 16-bit read, queue full, read limit, reset, and
// (with MC_MEM_BRIDGE_ALIGN_CHK_EN) a misaligned 32-bit read.
module tb_mc_mem_bridge;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ACT;
    logic        CMD;
    logic [1:0]  SIZE;
    logic [44:0] ADDRESS;
    logic [31:0] DTo;
    logic        NEXT;
    logic        DRDY;
    logic [31:0] DTi;
    logic        MEM_ACT;
    logic        MEM_CMD;
    logic [41:0] MEM_ADDR;
    logic [7:0]  MEM_BE;
    logic [63:0] MEM_DTO;
    logic        MEM_NEXT;
    logic        MEM_DRDY;
    logic [63:0] MEM_DTI;
    logic        ERR;

    int n_chk     = 0;
    int n_fail    = 0;
    int n_fire    = 0;
    int n_rd_fire = 0;

    mc_mem_bridge #(.QDEPTH(4), .RDEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .ACT(ACT), .CMD(CMD), .SIZE(SIZE),
        .ADDRESS(ADDRESS), .DTo(DTo), .NEXT(NEXT), .DRDY(DRDY), .DTi(DTi),
        .MEM_ACT(MEM_ACT), .MEM_CMD(MEM_CMD), .MEM_ADDR(MEM_ADDR),
        .MEM_BE(MEM_BE), .MEM_DTO(MEM_DTO), .MEM_NEXT(MEM_NEXT),
        .MEM_DRDY(MEM_DRDY), .MEM_DTI(MEM_DTI), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RESET && MEM_ACT && MEM_NEXT) begin
            n_fire <= n_fire + 1;
            if (MEM_CMD) n_rd_fire <= n_rd_fire + 1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic cmd, input logic [1:0] size, input logic [44:0] addr,
                        input logic [31:0] d);
        logic ok;
        ACT     = 1'b1;
        CMD     = cmd;
        SIZE    = size;
        ADDRESS = addr;
        DTo     = d;
        ok      = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (NEXT) ok = 1'b1;
            step();
        end
        ACT = 1'b0;
        chk("push_accept", 64'(ok), 64'd1);
    endtask

    logic [1:0]  rl_size [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
    logic [44:0] rl_addr [6] = '{45'h3, 45'h4, 45'h4, 45'h7, 45'h0, 45'h2};
    logic [31:0] rl_exp  [6] = '{32'h44, 32'h6655, 32'h8877_6655, 32'h88,
                                 32'h4433_2211, 32'h4433};

    int snap;

    initial begin
        RESET = 1'b0; ACT = 1'b0; CMD = 1'b0; SIZE = 2'b00; ADDRESS = '0; DTo = '0;
        MEM_NEXT = 1'b0; MEM_DRDY = 1'b0; MEM_DTI = '0;
        #3;
        chk("rst_next", 64'(NEXT), 64'd1);
        chk("rst_drdy", 64'(DRDY), 64'd0);
        chk("rst_dti", 64'(DTi), 64'd0);
        chk("rst_mem_act", 64'(MEM_ACT), 64'd0);
        chk("rst_mem_addr", 64'(MEM_ADDR), 64'd0);
        chk("rst_mem_be", 64'(MEM_BE), 64'd0);
        chk("rst_mem_dto", MEM_DTO, 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        #4 RESET = 1'b1;
        step();

        // Byte write at 0x1005
        MEM_NEXT = 1'b1;
        push(1'b0, 2'b00, 45'h1005, 32'hA5);
        chk("bw_latency", 64'(MEM_ACT), 64'd0);
        step();
        chk("bw_act", 64'(MEM_ACT), 64'd1);
        chk("bw_cmd", 64'(MEM_CMD), 64'd0);
        chk("bw_addr", 64'(MEM_ADDR), 64'h200);
        chk("bw_be", 64'(MEM_BE), 64'h20);
        chk("bw_dto", MEM_DTO, 64'hA5A5_A5A5_A5A5_A5A5);
        step();
        chk("bw_one_cycle", 64'(MEM_ACT), 64'd0);

        // 16-bit read at 0x6
        push(1'b1, 2'b01, 45'h6, 32'h0);
        step();
        chk("hr_act", 64'(MEM_ACT), 64'd1);
        chk("hr_cmd", 64'(MEM_CMD), 64'd1);
        chk("hr_be", 64'(MEM_BE), 64'hC0);
        step();
        chk("hr_issued", 64'(MEM_ACT), 64'd0);
        MEM_DRDY = 1'b1;
        MEM_DTI  = 64'h1122_3344_5566_7788;
        step();
        MEM_DRDY = 1'b0;
        chk("hr_drdy", 64'(DRDY), 64'd1);
        chk("hr_dti", 64'(DTi), 64'h1122);
        step();
        chk("hr_drdy_pulse", 64'(DRDY), 64'd0);
        chk("hr_dti_hold", 64'(DTi), 64'h1122);

        // Queue full with memory stalled
        MEM_NEXT = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, 2'b10, 45'h100 + 45'(8 * i), 32'(i));
        chk("qf_next_low", 64'(NEXT), 64'd0);
        ACT = 1'b1; CMD = 1'b0; SIZE = 2'b10; ADDRESS = 45'h120; DTo = 32'h4;
        step();
        step();
        chk("qf_held", 64'(NEXT), 64'd0);
        chk("qf_head_act", 64'(MEM_ACT), 64'd1);
        chk("qf_head_addr", 64'(MEM_ADDR), 64'h20);
        chk("qf_head_stable_be", 64'(MEM_BE), 64'h0F);
        MEM_NEXT = 1'b1;
        step();
        chk("qf_next_back", 64'(NEXT), 64'd1);
        chk("qf_drain1", 64'(MEM_ADDR), 64'h21);
        step();
        ACT = 1'b0;
        chk("qf_drain2", 64'(MEM_ADDR), 64'h22);
        step();
        chk("qf_drain3", 64'(MEM_ADDR), 64'h23);
        step();
        chk("qf_drain4", 64'(MEM_ADDR), 64'h24);
        chk("qf_drain4_act", 64'(MEM_ACT), 64'd1);
        step();
        chk("qf_empty_act", 64'(MEM_ACT), 64'd0);
        chk("qf_empty_next", 64'(NEXT), 64'd1);

        // Read limit: 6 reads, data withheld
        snap = n_rd_fire;
        for (int i = 0; i < 6; i++) push(1'b1, rl_size[i], rl_addr[i], 32'h0);
        for (int i = 0; i < 8; i++) step();
        chk("rl_issued4", 64'(n_rd_fire - snap), 64'd4);
        chk("rl_blocked", 64'(MEM_ACT), 64'd0);
        MEM_DTI = 64'h8877_6655_4433_2211;
        for (int k = 0; k < 6; k++) begin
            MEM_DRDY = 1'b1;
            step();
            MEM_DRDY = 1'b0;
            chk("rl_drdy", 64'(DRDY), 64'd1);
            chk("rl_dti", 64'(DTi), 64'(rl_exp[k]));
            step();
            chk("rl_drdy_pulse", 64'(DRDY), 64'd0);
            step();
            step();
        end
        chk("rl_issued6", 64'(n_rd_fire - snap), 64'd6);

        // Reset with one outstanding read and two queued writes
        MEM_NEXT = 1'b1;
        push(1'b1, 2'b00, 45'h8, 32'h0);
        step();
        step();
        MEM_NEXT = 1'b0;
        push(1'b0, 2'b00, 45'h10, 32'h11);
        push(1'b0, 2'b00, 45'h18, 32'h22);
        RESET = 1'b0;
        #2;
        chk("mr_next", 64'(NEXT), 64'd1);
        chk("mr_mem_act", 64'(MEM_ACT), 64'd0);
        chk("mr_drdy", 64'(DRDY), 64'd0);
        chk("mr_dti", 64'(DTi), 64'd0);
        chk("mr_mem_addr", 64'(MEM_ADDR), 64'd0);
        chk("mr_mem_be", 64'(MEM_BE), 64'd0);
        step();
        RESET    = 1'b1;
        MEM_NEXT = 1'b1;
        MEM_DRDY = 1'b1;
        MEM_DTI  = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        MEM_DRDY = 1'b0;
        chk("mr_late_drdy", 64'(DRDY), 64'd0);
        step();
        chk("mr_late_drdy2", 64'(DRDY), 64'd0);
        chk("mr_discarded", 64'(MEM_ACT), 64'd0);
        chk("mr_next_after", 64'(NEXT), 64'd1);

`ifdef MC_MEM_BRIDGE_ALIGN_CHK_EN
        begin
            logic        got;
            logic [31:0] seen;
            got  = 1'b0;
            seen = '0;
            snap = n_fire;
            push(1'b1, 2'b10, 45'h2, 32'h0);
            for (int i = 0; i < 10; i++) begin
                if (DRDY) begin
                    got  = 1'b1;
                    seen = DTi;
                end
                step();
            end
            chk("al_drdy", 64'(got), 64'd1);
            chk("al_dti", 64'(seen), 64'hFFFF_FFFF);
            chk("al_no_issue", 64'(n_fire - snap), 64'd0);
            chk("al_err", 64'(ERR), 64'd1);
        end
`else
        chk("err_tied", 64'(ERR), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
